ras_circular: RTL and testbench

Circular return-address stack for the CVA6 frontend branch predictor. It is parametrised in depth and address width, and supersedes the fixed shift-register RAS. Beyond the fixed RAS it adds three behaviours:
- overflow that wraps and overwrites the oldest entry,
- defined simultaneous push/pop (replace-top),
- snapshot/restore of stack state for misprediction recovery.

It sits between the frontend's call/return predecode and next-PC selection, sized from the core configuration's RAS depth.

---
 rtl/ras_circular.sv | 93 +++++++++
 tb/tb_ras_circular.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ras_circular.sv
// Circular return-address stack with overflow overwrite, replace-top on
// simultaneous push/pop, and pointer/count snapshot restore.
module ras_circular #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned VLEN  = 32,
    parameter int unsigned PTR_W = $clog2(DEPTH),
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [VLEN-1:0]  data_i,
    output logic [VLEN:0]    data_o,
    output logic [PTR_W-1:0] ptr_o,
    output logic [CNT_W-1:0] cnt_o,
    input  logic             restore_i,
    input  logic [PTR_W-1:0] restore_ptr_i,
    input  logic [CNT_W-1:0] restore_cnt_i
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [VLEN-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] tos_q;
    logic [PTR_W-1:0] tos_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             wr_en;
    logic [PTR_W-1:0] wr_ptr;
    logic             not_empty;

    assign not_empty = (cnt_q != '0);

    // Next pointer/count and write request, flush > restore > push/pop.
    always_comb begin
        tos_d  = tos_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_ptr = tos_q;
        if (flush_i) begin
            tos_d = '0;
            cnt_d = '0;
        end else if (restore_i) begin
            tos_d = restore_ptr_i;
            cnt_d = (restore_cnt_i > CNT_MAX) ? CNT_MAX : restore_cnt_i;
        end else if (push_i && pop_i && not_empty) begin
            // Replace-top: return then call nets to an overwrite in place.
            wr_en  = 1'b1;
            wr_ptr = tos_q;
        end else if (push_i) begin
            // On a full stack the slot after tos is the oldest entry.
            tos_d  = tos_q + PTR_ONE;
            wr_en  = 1'b1;
            wr_ptr = tos_q + PTR_ONE;
            cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        end else if (pop_i && not_empty) begin
            tos_d = tos_q - PTR_ONE;
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tos_q <= '0;
            cnt_q <= '0;
        end else begin
            tos_q <= tos_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; cleared on reset, otherwise one write per cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_ptr] <= data_i;
        end
    end

    // Top entry is only visible while the stack holds something.
    assign data_o = {not_empty, not_empty ? mem_q[tos_q] : {VLEN{1'b0}}};
    assign ptr_o  = tos_q;
    assign cnt_o  = cnt_q;

endmodule

// File: tb/tb_ras_circular.sv
// Directed and randomized checks of ras_circular against a behavioural model.
module tb_ras_circular;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned VLEN  = 32;
    localparam int unsigned PTR_W = 2;
    localparam int unsigned CNT_W = 3;

    logic             clk;
    logic             rst_ni;
    logic             flush_i;
    logic             push_i;
    logic             pop_i;
    logic [VLEN-1:0]  data_i;
    logic [VLEN:0]    data_o;
    logic [PTR_W-1:0] ptr_o;
    logic [CNT_W-1:0] cnt_o;
    logic             restore_i;
    logic [PTR_W-1:0] restore_ptr_i;
    logic [CNT_W-1:0] restore_cnt_i;

    int checks;
    int failures;

    // Reference model: plain integer stack with modulo indexing.
    logic [VLEN-1:0] m_mem [DEPTH];
    int              m_tos;
    int              m_cnt;

    ras_circular #(
        .DEPTH(DEPTH), .VLEN(VLEN), .PTR_W(PTR_W), .CNT_W(CNT_W)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .push_i       (push_i),
        .pop_i        (pop_i),
        .data_i       (data_i),
        .data_o       (data_o),
        .ptr_o        (ptr_o),
        .cnt_o        (cnt_o),
        .restore_i    (restore_i),
        .restore_ptr_i(restore_ptr_i),
        .restore_cnt_i(restore_cnt_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
        m_tos = 0;
        m_cnt = 0;
    endtask

    // Applies the currently driven request to the model, as the next edge will.
    task automatic model_step();
        if (flush_i) begin
            m_tos = 0;
            m_cnt = 0;
        end else if (restore_i) begin
            m_tos = int'(restore_ptr_i);
            m_cnt = (int'(restore_cnt_i) > int'(DEPTH)) ? int'(DEPTH) : int'(restore_cnt_i);
        end else if (push_i && pop_i && m_cnt > 0) begin
            m_mem[m_tos] = data_i;
        end else if (push_i) begin
            m_tos = (m_tos + 1) % int'(DEPTH);
            m_mem[m_tos] = data_i;
            if (m_cnt < int'(DEPTH)) m_cnt++;
        end else if (pop_i && m_cnt > 0) begin
            m_tos = (m_tos + int'(DEPTH) - 1) % int'(DEPTH);
            m_cnt--;
        end
    endtask

    task automatic check_model(input string tag);
        logic [VLEN:0] exp_data;
        exp_data = (m_cnt != 0) ? {1'b1, m_mem[m_tos]} : '0;
        chk({tag, ".data"}, 64'(data_o), 64'(exp_data));
        chk({tag, ".ptr"},  64'(ptr_o),  64'(m_tos));
        chk({tag, ".cnt"},  64'(cnt_o),  64'(m_cnt));
    endtask

    task automatic idle_inputs();
        flush_i       = 1'b0;
        push_i        = 1'b0;
        pop_i         = 1'b0;
        data_i        = '0;
        restore_i     = 1'b0;
        restore_ptr_i = '0;
        restore_cnt_i = '0;
    endtask

    // One clock with the driven inputs, then model comparison after the edge.
    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_model(tag);
        idle_inputs();
    endtask

    task automatic do_op(input string tag, input logic pu, input logic po, input logic [VLEN-1:0] d);
        push_i = pu;
        pop_i  = po;
        data_i = d;
        tick(tag);
    endtask

    task automatic do_restore(input string tag, input logic [PTR_W-1:0] p, input logic [CNT_W-1:0] c);
        restore_i     = 1'b1;
        restore_ptr_i = p;
        restore_cnt_i = c;
        tick(tag);
    endtask

    function automatic logic [63:0] valid_val(input logic [VLEN-1:0] v);
        return 64'({1'b1, v});
    endfunction

    initial begin
        logic [PTR_W-1:0] snap_ptr;
        checks   = 0;
        failures = 0;
        idle_inputs();
        model_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.data", 64'(data_o), 64'h0);
        chk("reset.ptr",  64'(ptr_o),  64'h0);
        chk("reset.cnt",  64'(cnt_o),  64'h0);
        #2 rst_ni = 1'b1;

        // Underflow pop is ignored.
        do_op("empty_pop", 1'b0, 1'b1, '0);
        chk("empty_pop.cnt", 64'(cnt_o), 64'h0);

        // LIFO order.
        do_op("lifo_push1", 1'b1, 1'b0, 32'h100);
        do_op("lifo_push2", 1'b1, 1'b0, 32'h200);
        do_op("lifo_push3", 1'b1, 1'b0, 32'h300);
        chk("lifo.top", 64'(data_o), valid_val(32'h300));
        chk("lifo.cnt", 64'(cnt_o), 64'd3);
        chk("lifo.pop1", 64'(data_o), valid_val(32'h300));
        do_op("lifo_pop1", 1'b0, 1'b1, '0);
        chk("lifo.pop2", 64'(data_o), valid_val(32'h200));
        do_op("lifo_pop2", 1'b0, 1'b1, '0);
        chk("lifo.pop3", 64'(data_o), valid_val(32'h100));
        do_op("lifo_pop3", 1'b0, 1'b1, '0);
        chk("lifo.empty_data", 64'(data_o), 64'h0);
        chk("lifo.empty_cnt", 64'(cnt_o), 64'h0);

        // Overflow wrap overwrites the oldest entries.
        for (int i = 1; i <= 6; i++) do_op("ovf_push", 1'b1, 1'b0, VLEN'(i));
        chk("ovf.cnt", 64'(cnt_o), 64'd4);
        chk("ovf.ptr", 64'(ptr_o), 64'd2);
        for (int i = 6; i >= 3; i--) begin
            chk("ovf.pop", 64'(data_o), valid_val(VLEN'(i)));
            do_op("ovf_pop", 1'b0, 1'b1, '0);
        end
        chk("ovf.empty", 64'(data_o), 64'h0);

        // Simultaneous push/pop replaces the top.
        do_op("pp_a", 1'b1, 1'b0, 32'hA);
        do_op("pp_b", 1'b1, 1'b0, 32'hB);
        do_op("pp_rep", 1'b1, 1'b1, 32'hC);
        chk("pp.top", 64'(data_o), valid_val(32'hC));
        chk("pp.cnt", 64'(cnt_o), 64'd2);
        do_op("pp_pop", 1'b0, 1'b1, '0);
        chk("pp.after_pop", 64'(data_o), valid_val(32'hA));
        do_op("pp_drain", 1'b0, 1'b1, '0);
        do_op("pp_empty", 1'b1, 1'b1, 32'hD);
        chk("pp.empty_top", 64'(data_o), valid_val(32'hD));
        chk("pp.empty_cnt", 64'(cnt_o), 64'd1);
        do_op("pp_drain2", 1'b0, 1'b1, '0);

        // Snapshot and restore.
        do_op("snap_p1", 1'b1, 1'b0, 32'h11);
        do_op("snap_p2", 1'b1, 1'b0, 32'h22);
        snap_ptr = ptr_o;
        chk("snap.cnt", 64'(cnt_o), 64'd2);
        do_op("snap_p7", 1'b1, 1'b0, 32'h7);
        repeat (3) do_op("snap_pop", 1'b0, 1'b1, '0);
        do_restore("restore", snap_ptr, CNT_W'(2));
        chk("restore.ptr", 64'(ptr_o), 64'(snap_ptr));
        chk("restore.cnt", 64'(cnt_o), 64'd2);
        chk("restore.data", 64'(data_o), valid_val(32'h22));
        do_restore("restore_sat", snap_ptr, CNT_W'(7));
        chk("restore_sat.cnt", 64'(cnt_o), 64'd4);

        // Flush beats a same-cycle push.
        flush_i = 1'b1;
        do_op("flush_push", 1'b1, 1'b0, 32'h55);
        chk("flush.cnt", 64'(cnt_o), 64'h0);
        chk("flush.valid", 64'(data_o[VLEN]), 64'h0);

        // Asynchronous reset between edges.
        do_op("ar_p1", 1'b1, 1'b0, 32'h31);
        do_op("ar_p2", 1'b1, 1'b0, 32'h32);
        do_op("ar_p3", 1'b1, 1'b0, 32'h33);
        #2 rst_ni = 1'b0;
        #1;
        model_reset();
        chk("async_rst.data", 64'(data_o), 64'h0);
        chk("async_rst.ptr",  64'(ptr_o),  64'h0);
        chk("async_rst.cnt",  64'(cnt_o),  64'h0);
        #1 rst_ni = 1'b1;

        // Random back-to-back traffic.
        for (int n = 0; n < 400; n++) begin
            int sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 3) begin
                flush_i = 1'b1;
            end else if (sel < 9) begin
                restore_i     = 1'b1;
                restore_ptr_i = PTR_W'($urandom_range(0, DEPTH - 1));
                restore_cnt_i = CNT_W'($urandom_range(0, 7));
            end
            push_i = 1'($urandom_range(0, 1));
            pop_i  = 1'($urandom_range(0, 1));
            data_i = VLEN'($urandom);
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
